// File: rtl/i2c_bus_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_bus_sequencer
// Master-side I2C byte sequencer on the 10 MHz domain. It runs
// Start / chip address / register address / data / Stop phases and drives
// open-drain SCL/SDA. It exports the current bus state and the per-state tick
// timer that the register-address calculator consumes.
//
// Optional feature: define I2C_CLK_STRETCH_EN to honour slave clock
// stretching. Without it, i_SCL is ignored and bit timing is fixed.
//
// Ports
//   i_clk10MHz, i_RST_n      clock, async active-low reset
//   i_Go/i_RW/i_Chip_Addr/   command, captured when i_Go is seen in Idle
//   i_Byte_Count
//   i_Reg_Addr               register address, sampled at Reg_Addr_Send tick 0
//   i_Read_Setting_Flag      1 = device pointer already valid (current-addr read)
//   i_Wr_Data/o_Wr_Data_Req  write byte, consumed at Data_Send tick 0
//   i_SDA, i_SCL             pad inputs
//   o_SCL_Oe, o_SDA_Oe       1 = pull the line low
//   o_Current_State          Idle=0 Start=1 Chip=2 Reg=3 DSend=4 DRcv=5 Stop=6
//   o_Clock_Timer            tick count within state / byte
//   o_Rd_Data/o_Data_Valid   received byte + one-cycle strobe
//   o_Busy, o_Nack_Err       busy level, sticky slave-NACK flag
// -----------------------------------------------------------------------------
module i2c_bus_sequencer #(
    parameter int BIT_TICKS = 25
) (
    input  logic       i_clk10MHz,
    input  logic       i_RST_n,
    input  logic       i_Go,
    input  logic       i_RW,
    input  logic [6:0] i_Chip_Addr,
    input  logic [7:0] i_Byte_Count,
    input  logic [7:0] i_Reg_Addr,
    input  logic       i_Read_Setting_Flag,
    input  logic [7:0] i_Wr_Data,
    input  logic       i_SDA,
    input  logic       i_SCL,
    output logic       o_SCL_Oe,
    output logic       o_SDA_Oe,
    output logic [2:0] o_Current_State,
    output logic [7:0] o_Clock_Timer,
    output logic       o_Wr_Data_Req,
    output logic [7:0] o_Rd_Data,
    output logic       o_Data_Valid,
    output logic       o_Busy,
    output logic       o_Nack_Err
);
    localparam logic [4:0] BT_LAST  = 5'(BIT_TICKS - 1);
    localparam logic [4:0] BT_HALF  = 5'(BIT_TICKS / 2);
    localparam logic [4:0] BT_SAMP  = 5'((3 * BIT_TICKS) / 4);
    localparam logic [7:0] T_BIT    = 8'(BIT_TICKS);
    localparam logic [7:0] T_STOP_H = 8'(BIT_TICKS + BIT_TICKS / 2);
    localparam logic [7:0] T_PHASE  = 8'(2 * BIT_TICKS - 1);
    localparam logic [7:0] T_RXDONE = 8'(8 * BIT_TICKS - 1);
    localparam logic [7:0] T_BYTE   = 8'(9 * BIT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CHIP  = 3'd2,
        S_REG   = 3'd3,
        S_DSEND = 3'd4,
        S_DRCV  = 3'd5,
        S_STOP  = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic [4:0] bit_tick;              // tick within the current bit
    logic [3:0] bit_idx;               // 0..7 data, 8 = ACK
    logic       rw_q;
    logic [6:0] chip_q;
    logic [7:0] remain_q;              // data bytes still to move, incl. current
    logic [7:0] tx_q, rx_q;
    logic       nack_q;                // NACK seen on the current byte
    logic [7:0] tx_live, tx_cur;
    logic       byte_st, stall, byte_end, phase_end, last_byte, samp_now;
    logic       scl_oe, sda_oe;

    assign byte_st   = (state == S_CHIP) || (state == S_REG) ||
                       (state == S_DSEND) || (state == S_DRCV);
    assign byte_end  = byte_st && !stall && (timer == T_BYTE);
    assign phase_end = (timer == T_PHASE);
    assign last_byte = (remain_q == 8'd1);
    assign samp_now  = byte_st && !stall && (bit_tick == BT_SAMP);

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low while we have released it: freeze all timing.
    assign stall = byte_st && (bit_tick >= BT_HALF) && !i_SCL;
`else
    assign stall = 1'b0 & i_SCL;
`endif

    // The byte to shift is taken from its source on tick 0 and held in tx_q
    // afterwards; bit 7 goes out on tick 0 itself, so bypass the register then.
    always_comb begin
        tx_live = 8'h00;
        case (state)
            S_CHIP:  tx_live = {chip_q, rw_q & i_Read_Setting_Flag};
            S_REG:   tx_live = i_Reg_Addr;
            S_DSEND: tx_live = i_Wr_Data;
            default: tx_live = 8'h00;
        endcase
    end
    assign tx_cur = (timer == 8'd0) ? tx_live : tx_q;

    always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state <= S_IDLE;
            timer <= 8'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = stall ? timer : timer + 8'd1;
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = 8'd0;
                if (i_Go) state_nxt = S_START;
            end
            S_START: begin
                sda_oe = (timer >= T_BIT);
                if (phase_end) begin
                    state_nxt = S_CHIP;
                    timer_nxt = 8'd0;
                end
            end
            S_CHIP: if (byte_end) begin
                timer_nxt = 8'd0;
                if (nack_q)       state_nxt = S_STOP;
                else if (tx_q[0]) state_nxt = S_DRCV;
                else              state_nxt = S_REG;
            end
            S_REG: if (byte_end) begin
                timer_nxt = 8'd0;
                if (nack_q)    state_nxt = S_STOP;
                else if (rw_q) state_nxt = S_START;   // repeated Start for read
                else           state_nxt = S_DSEND;
            end
            S_DSEND: if (byte_end) begin
                timer_nxt = 8'd0;
                if (nack_q || last_byte) state_nxt = S_STOP;
            end
            S_DRCV: if (byte_end) begin
                timer_nxt = 8'd0;
                if (last_byte) state_nxt = S_STOP;
            end
            S_STOP: begin
                scl_oe = (timer < T_BIT);
                sda_oe = (timer < T_STOP_H);
                if (phase_end) begin
                    state_nxt = S_IDLE;
                    timer_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = 8'd0;
            end
        endcase
        if (byte_st) begin
            scl_oe = (bit_tick < BT_HALF);
            if (bit_idx == 4'd8)
                sda_oe = (state == S_DRCV) && !last_byte;   // master ACK, NACK on last
            else
                sda_oe = (state != S_DRCV) && !tx_cur[3'd7 - bit_idx[2:0]];
        end
    end

    always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            bit_tick     <= 5'd0;
            bit_idx      <= 4'd0;
            rw_q         <= 1'b0;
            chip_q       <= 7'd0;
            remain_q     <= 8'd0;
            tx_q         <= 8'd0;
            rx_q         <= 8'd0;
            nack_q       <= 1'b0;
            o_Rd_Data    <= 8'd0;
            o_Data_Valid <= 1'b0;
            o_Nack_Err   <= 1'b0;
        end else begin
            o_Data_Valid <= 1'b0;
            if (state == S_IDLE && i_Go) begin
                rw_q       <= i_RW;
                chip_q     <= i_Chip_Addr;
                remain_q   <= (i_Byte_Count == 8'd0) ? 8'd1 : i_Byte_Count;
                o_Nack_Err <= 1'b0;
            end
            if (state_nxt != state || byte_end) begin
                bit_tick <= 5'd0;
                bit_idx  <= 4'd0;
            end else if (byte_st && !stall) begin
                if (bit_tick == BT_LAST) begin
                    bit_tick <= 5'd0;
                    bit_idx  <= bit_idx + 4'd1;
                end else begin
                    bit_tick <= bit_tick + 5'd1;
                end
            end
            if (byte_st && timer == 8'd0) begin
                tx_q   <= tx_live;
                nack_q <= 1'b0;
            end
            if (samp_now && bit_idx != 4'd8)
                rx_q <= {rx_q[6:0], i_SDA};
            if (samp_now && bit_idx == 4'd8 && state != S_DRCV && i_SDA) begin
                nack_q     <= 1'b1;
                o_Nack_Err <= 1'b1;
            end
            // All 8 data bits are in by the last tick of bit 7.
            if (state == S_DRCV && !stall && timer == T_RXDONE) begin
                o_Rd_Data    <= rx_q;
                o_Data_Valid <= 1'b1;
            end
            if (byte_end && (state == S_DSEND || state == S_DRCV))
                remain_q <= remain_q - 8'd1;
        end
    end

    assign o_SCL_Oe        = scl_oe;
    assign o_SDA_Oe        = sda_oe;
    assign o_Current_State = state;
    assign o_Clock_Timer   = timer;
    assign o_Wr_Data_Req   = (state == S_DSEND) && (timer == 8'd0);
    assign o_Busy          = (state != S_IDLE);
endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for i2c_bus_sequencer. A small open-drain slave model decodes
// the bus (Start markers plus {ack, byte} entries) and answers reads with 0x5A.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_bus_sequencer;
    localparam int BT = 25;
    localparam int START_MARK = 'h1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_Go = 1'b0, i_RW = 1'b0;
    logic [6:0] i_Chip_Addr = 7'h50;
    logic [7:0] i_Byte_Count = 8'd2;
    logic [7:0] i_Reg_Addr = 8'h10;
    logic       i_Read_Setting_Flag, i_SDA, i_SCL;
    logic [7:0] i_Wr_Data;
    logic       o_SCL_Oe, o_SDA_Oe, o_Wr_Data_Req, o_Data_Valid, o_Busy, o_Nack_Err;
    logic [2:0] o_Current_State;
    logic [7:0] o_Clock_Timer, o_Rd_Data;

    logic       scl_hold = 1'b0, nack_mode = 1'b0, flag_base = 1'b0, flag_auto = 1'b0;
    logic       mon_clr = 1'b0, seen_reg, slv_drv;
    logic [7:0] rd_byte = 8'h5A;
    logic [7:0] wr_bytes [0:3] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    int         wr_idx, nbusy, nreq, nval, st_sig, hi_cnt, n_chk = 0, n_fail = 0;
    logic [2:0] last_st;
    int         slog[$], exp_q[$];
    logic       prev_scl, prev_sda, is_rd, done;
    logic [3:0] bcnt;
    int         nbyte;
    logic [7:0] sh;
    logic       scl_bus, sda_bus;

    always #50 clk = ~clk;

    assign scl_bus = ~o_SCL_Oe & ~scl_hold;
    assign sda_bus = ~o_SDA_Oe & ~slv_drv;
    assign i_SCL = scl_bus;
    assign i_SDA = sda_bus;
    assign i_Wr_Data = wr_bytes[wr_idx[1:0]];
    assign i_Read_Setting_Flag = flag_base | (flag_auto & seen_reg);

    i2c_bus_sequencer #(.BIT_TICKS(BT)) dut (
        .i_clk10MHz(clk), .i_RST_n(rst_n), .i_Go(i_Go), .i_RW(i_RW),
        .i_Chip_Addr(i_Chip_Addr), .i_Byte_Count(i_Byte_Count), .i_Reg_Addr(i_Reg_Addr),
        .i_Read_Setting_Flag(i_Read_Setting_Flag), .i_Wr_Data(i_Wr_Data),
        .i_SDA(i_SDA), .i_SCL(i_SCL), .o_SCL_Oe(o_SCL_Oe), .o_SDA_Oe(o_SDA_Oe),
        .o_Current_State(o_Current_State), .o_Clock_Timer(o_Clock_Timer),
        .o_Wr_Data_Req(o_Wr_Data_Req), .o_Rd_Data(o_Rd_Data), .o_Data_Valid(o_Data_Valid),
        .o_Busy(o_Busy), .o_Nack_Err(o_Nack_Err)
    );

    always @(posedge clk) begin
        if (mon_clr) wr_idx <= 0;
        else if (o_Wr_Data_Req) wr_idx <= wr_idx + 1;
    end

    // Activity monitor: busy cycles, strobes, and the sequence of states
    // visited packed one octal digit per state.
    always @(negedge clk) begin
        if (mon_clr) begin
            nbusy <= 0; nreq <= 0; nval <= 0; st_sig <= 0; last_st <= 3'd0; seen_reg <= 1'b0;
        end else begin
            if (o_Busy) nbusy <= nbusy + 1;
            if (o_Wr_Data_Req) nreq <= nreq + 1;
            if (o_Data_Valid) nval <= nval + 1;
            if (o_Busy && o_Current_State != last_st)
                st_sig <= (st_sig << 3) | int'(o_Current_State);
            last_st <= o_Current_State;
            if (o_Current_State == 3'd3) seen_reg <= 1'b1;
        end
    end

    // Slave model. Releases a held ACK if SCL stays high a full bit period,
    // which only happens when the master moves into a (repeated) Start.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_scl <= 1'b1; prev_sda <= 1'b1; bcnt <= 4'd0; nbyte <= 0;
            is_rd <= 1'b0; sh <= 8'd0; slv_drv <= 1'b0; hi_cnt <= 0; done <= 1'b0;
        end else begin
            if (mon_clr) slog.delete();
            prev_scl <= scl_bus;
            prev_sda <= sda_bus;
            hi_cnt   <= scl_bus ? hi_cnt + 1 : 0;
            if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
                bcnt <= 4'd0; nbyte <= 0; done <= 1'b0;
                slog.push_back(START_MARK);
            end else if (!prev_scl && scl_bus) begin
                if (bcnt == 4'd8) begin
                    slog.push_back(int'({sda_bus, sh}));
                    bcnt  <= 4'd0;
                    nbyte <= nbyte + 1;
                    if (nbyte == 0) is_rd <= sh[0];
                    if (is_rd && nbyte != 0 && sda_bus) done <= 1'b1;
                end else begin
                    sh   <= {sh[6:0], sda_bus};
                    bcnt <= bcnt + 4'd1;
                end
            end else if (prev_scl && !scl_bus) begin
                if (bcnt == 4'd8)
                    slv_drv <= (nbyte == 0 || !is_rd) && !nack_mode;
                else if (is_rd && nbyte != 0 && !done)
                    slv_drv <= ~rd_byte[3'd7 - bcnt[2:0]];
                else
                    slv_drv <= 1'b0;
            end else if (hi_cnt == BT) begin
                slv_drv <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, ".nent"}, slog.size(), exp_q.size());
        foreach (exp_q[i])
            check_eq($sformatf("%s.ent%0d", tag, i), (i < slog.size()) ? slog[i] : -1, exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go(input logic rw, input logic [7:0] cnt, input string tag);
        tick(); mon_clr = 1'b1; i_RW = rw; i_Byte_Count = cnt;
        tick(); mon_clr = 1'b0; i_Go = 1'b1;
        tick(); i_Go = 1'b0;
        check_eq({tag, ".start"}, int'(o_Current_State), 1);
        check_eq({tag, ".nack_clr"}, int'(o_Nack_Err), 0);
    endtask

    task automatic run_txn(input logic rw, input logic [7:0] cnt, input int exp_busy,
                           input string tag);
        int g = 0;
        go(rw, cnt, tag);
        while (o_Busy && g < 5000) begin tick(); g++; end
        check_eq({tag, ".idle"}, int'(g < 5000), 1);
        check_eq({tag, ".busy_cyc"}, nbusy, exp_busy);
    endtask

    initial begin
        #120;
        check_eq("rst.state", int'(o_Current_State), 0);
        check_eq("rst.timer", int'(o_Clock_Timer), 0);
        check_eq("rst.oe", int'({o_SCL_Oe, o_SDA_Oe}), 0);
        check_eq("rst.busy", int'(o_Busy), 0);
        check_eq("rst.pulses", int'({o_Wr_Data_Req, o_Data_Valid}), 0);
        check_eq("rst.nack", int'(o_Nack_Err), 0);
        tick(); rst_n = 1'b1;

        // Write 2 bytes
        run_txn(1'b0, 8'd2, (2 + 9 * (2 + 2) + 2) * BT, "wr");
        exp_q = {START_MARK, 'h0A0, 'h010, 'h0A5, 'h03C};
        check_log("wr");
        check_eq("wr.req", nreq, 2);
        check_eq("wr.states", st_sig, 'o12346);
        check_eq("wr.nack", int'(o_Nack_Err), 0);

        // Random read: flag rises once Reg_Addr_Send has been seen
        flag_auto = 1'b1;
        run_txn(1'b1, 8'd1, (2 + 9 + 9 + 2 + 9 + 9 + 2) * BT, "rd");
        exp_q = {START_MARK, 'h0A0, 'h010, START_MARK, 'h0A1, 'h15A};
        check_log("rd");
        check_eq("rd.states", st_sig, 'o1231256);
        check_eq("rd.valid", nval, 1);
        check_eq("rd.data", int'(o_Rd_Data), 'h5A);
        flag_auto = 1'b0;

        // Current-address read
        flag_base = 1'b1;
        run_txn(1'b1, 8'd0, (2 + 9 + 9 + 2) * BT, "cur");
        exp_q = {START_MARK, 'h0A1, 'h15A};
        check_log("cur");
        check_eq("cur.states", st_sig, 'o1256);
        check_eq("cur.data", int'(o_Rd_Data), 'h5A);
        flag_base = 1'b0;

        // Slave NACKs the chip address
        nack_mode = 1'b1;
        run_txn(1'b0, 8'd2, (2 + 9 + 2) * BT, "nack");
        exp_q = {START_MARK, 'h1A0};
        check_log("nack");
        check_eq("nack.err", int'(o_Nack_Err), 1);
        check_eq("nack.states", st_sig, 'o126);
        check_eq("nack.req", nreq, 0);
        nack_mode = 1'b0;
        run_txn(1'b0, 8'd1, (2 + 9 * (2 + 1) + 2) * BT, "nack2");  // Go clears the flag
        check_eq("nack2.err", int'(o_Nack_Err), 0);

        // Reset at Data_Send timer 100
        begin
            int g = 0;
            go(1'b0, 8'd2, "rstm");
            while (!(o_Current_State == 3'd4 && o_Clock_Timer == 8'd100) && g < 3000) begin
                tick(); g++;
            end
            check_eq("rstm.reach", int'(g < 3000), 1);
            rst_n = 1'b0;
            #1;
            check_eq("rstm.state", int'(o_Current_State), 0);
            check_eq("rstm.timer", int'(o_Clock_Timer), 0);
            check_eq("rstm.oe", int'({o_SCL_Oe, o_SDA_Oe}), 0);
            check_eq("rstm.busy", int'(o_Busy), 0);
            check_eq("rstm.rd", int'(o_Rd_Data), 0);
            check_eq("rstm.bus", int'({scl_bus, sda_bus}), 3);
            tick(); tick(); rst_n = 1'b1;
        end

`ifdef I2C_CLK_STRETCH_EN
        fork
            run_txn(1'b0, 8'd2, (2 + 9 * (2 + 2) + 2) * BT + 40, "str");
            begin
                int g = 0;
                while (!(o_Current_State == 3'd2 && o_Clock_Timer == 8'(3 * BT + BT / 2)) && g < 3000) begin
                    tick(); g++;
                end
                check_eq("str.reach", int'(g < 3000), 1);
                scl_hold = 1'b1;
                repeat (20) tick();
                check_eq("str.frozen", int'(o_Clock_Timer), 3 * BT + BT / 2);
                repeat (20) tick();
                scl_hold = 1'b0;
            end
        join
        exp_q = {START_MARK, 'h0A0, 'h010, 'h0A5, 'h03C};
        check_log("str");
        check_eq("str.req", nreq, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
